io_port_responder: RTL and testbench
====================================

// Module: io_port_responder
// PURPOSE
// - Peripheral-side responder for the CPU's word I/O handshake (inp_req/inp_ack, out_req/out_ack).
// - Buffers words from an external source in an RX FIFO for the CPU's input instruction; buffers CPU output words in a TX FIFO for an external sink.
// - Sits between the CPU I/O pins and the testbench/board-level stream interfaces.
// PARAMETERS
// - DW       16  data word width (matches CPU data path)
// - DEPTH    8   entries per FIFO, power of two, >= 2
// - ACK_LAT  1   cycles from sampled req to ack, >= 1 (extra wait states)
// PORTS
// - clk          in   1         single clock, rising edge
// - rst_b        in   1         asynchronous active-low reset
// - inp_req      in   1         CPU requests an input word (level, held until inp_ack)
// - inp_ack      out  1         one-cycle pulse; inp_data valid this cycle
// - inp_data     out  DW        word popped from RX FIFO
// - out_req      in   1         CPU offers out_data (level, held until out_ack)
// - out_data     in   DW        CPU output word, stable while out_req high
// - out_ack      out  1         one-cycle pulse; word accepted into TX FIFO
// - rx_valid     in   1         external source has rx_data
// - rx_data      in   DW        external input word
// - rx_ready     out  1         RX FIFO not full (push on rx_valid & rx_ready)
// - tx_valid     out  1         TX FIFO not empty
// - tx_data      out  DW        TX FIFO head word
// - tx_ready     in   1         external sink pops on tx_valid & tx_ready
// - rx_count     out  $clog2(DEPTH)+1  RX occupancy
// - tx_count     out  $clog2(DEPTH)+1  TX occupancy
// BEHAVIOUR
// - Reset: FIFOs empty, both FSMs IDLE; inp_ack=0, out_ack=0, inp_data=0, rx_ready=1, tx_valid=0, counts=0. Reset mid-transaction aborts it; no ack is issued.
// - Two independent channel FSMs, states IDLE -> WAIT -> ACK -> REL -> IDLE.
//   IDLE: req high -> WAIT, load lat counter with ACK_LAT-1.
//   WAIT: counter decrements to 0; leave only when counter==0 AND FIFO ready (RX non-empty / TX non-full), else stall indefinitely.
//   ACK: ack=1 for exactly one cycle; RX pops (inp_data registered on WAIT->ACK edge) / TX pushes out_data.
//   REL: wait for req low; no second ack until req has been sampled low for >= 1 cycle.
// - Latency with ACK_LAT=1 and FIFO ready: req sampled high cycle N -> ack high cycle N+2.
// - inp_data holds last delivered word until next ACK.
// - req dropped while in WAIT: return to IDLE, no FIFO side effect.
// - FIFO full: rx_ready=0, rx_data ignored. Empty: tx_valid=0, tx_data=last head (don't-care).
// - Simultaneous push+pop on same FIFO: both occur, count unchanged; allowed at full (pop frees slot same cycle is NOT used: push at full refused) and at empty (pop refused).
// - Pointers wrap modulo DEPTH; count saturates never (guarded by full/empty).
// CONFIGURATION
// - IO_PORT_LOOPBACK_EN defined: extra input port loopback (1 bit). When high, TX-channel ACK pushes out_data into RX FIFO instead of TX FIFO; rx_ready forced 0 (loopback has sole RX write access); WAIT on TX channel checks RX not-full.
// - Undefined: no loopback port; RX written only from rx_* side.
// STRUCTURE
// - io_port_defs.vh: FSM state encodings (IDLE/WAIT/ACK/REL, 2-bit), DW default.
// - One sub-module: io_sync_fifo (DW, DEPTH; push, pop, full, empty, count, head), instantiated twice.
// - Channel FSMs and lat counters live in the top; no other hierarchy.
// TESTING
// - Source pushes 16'h1234, 16'hABCD; CPU inp_req x2 -> inp_data 16'h1234 then 16'hABCD, one ack each, rx_count 2->0.
// - inp_req with RX empty for 10 cycles, then push 16'h00FF -> inp_ack 2 cycles after push lands, inp_data=16'h00FF.
// - 9 CPU out_req writes (DEPTH=8), tx_ready=0 -> 8 acks, 9th stalls; tx_ready=1 one cycle -> 9th acks, tx_count stays 8.
// - req held high after ack for 5 cycles -> exactly one ack; drop 1 cycle, raise -> second ack.
// - rst_b pulsed low during WAIT with out_req high -> no out_ack, tx_count=0, all outputs at reset values.
// - IO_PORT_LOOPBACK_EN, loopback=1: out_data 16'h5A5A -> out_ack, then inp_req -> inp_data 16'h5A5A, tx_valid stays 0.

Source files
------------

// File: rtl/io_port_responder_pkg.sv
// Shared types and defaults for the io_port_responder slice.
// Holds the channel FSM encoding and a width helper for the latency timer.
package io_port_responder_pkg;

  localparam int IO_DW_DEF      = 16;
  localparam int IO_DEPTH_DEF   = 8;
  localparam int IO_ACK_LAT_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_REL  = 2'd3
  } io_state_e;

  // Timer only ever holds ACK_LAT-1, so clog2(ACK_LAT) bits suffice (min 1).
  function automatic int io_lat_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/io_port_responder_if.sv
// CPU word-I/O handshake plus RX/TX stream bundle for io_port_responder.
// The slave modport is the responder's view; master is the CPU/board side.
interface io_port_responder_if #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          inp_req;
  logic          inp_ack;
  logic [DW-1:0] inp_data;
  logic          out_req;
  logic [DW-1:0] out_data;
  logic          out_ack;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_ready;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;

  modport slave (
    input  inp_req, out_req, out_data, rx_valid, rx_data, tx_ready,
    output inp_ack, inp_data, out_ack, rx_ready, tx_valid, tx_data,
           rx_count, tx_count
  );

  modport master (
    output inp_req, out_req, out_data, rx_valid, rx_data, tx_ready,
    input  inp_ack, inp_data, out_ack, rx_ready, tx_valid, tx_data,
           rx_count, tx_count
  );

endinterface

// File: rtl/io_port_responder_sync_fifo.sv
// io_sync_fifo: single-clock FIFO with occupancy count and registered head.
// Push at full and pop at empty are silently refused.
module io_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DW-1:0]            head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // DEPTH is a power of two, so the pointers wrap on their own.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/io_port_responder.sv
// Peripheral responder for the CPU word-I/O handshake with RX/TX FIFOs.
// Optional IO_PORT_LOOPBACK_EN adds a loopback input routing CPU output words into RX.
//
// state | meaning
// IDLE  | no request pending
// WAIT  | request seen; latency timer running / waiting for FIFO readiness
// ACK   | one-cycle ack; RX pops or TX pushes this cycle
// REL   | ack given; waiting for the CPU to drop req
module io_port_responder
  import io_port_responder_pkg::*;
#(
  parameter int DW      = IO_DW_DEF,
  parameter int DEPTH   = IO_DEPTH_DEF,
  parameter int ACK_LAT = IO_ACK_LAT_DEF
) (
  input logic                clk,
  input logic                rst_b,
  io_port_responder_if.slave bus
`ifdef IO_PORT_LOOPBACK_EN
  ,
  input logic                loopback
`endif
);
  localparam int LW = io_lat_w(ACK_LAT);
  localparam int CW = $clog2(DEPTH) + 1;

  // Channel index 0 is the CPU input (RX) side, 1 the CPU output (TX) side.
  logic [1:0] req;
  logic [1:0] ready;
  logic [1:0] ack;
  logic [1:0] take;

  logic          rx_full, rx_empty, rx_push;
  logic [DW-1:0] rx_din, rx_head;
  logic [CW-1:0] rx_cnt;
  logic          tx_full, tx_empty, tx_push;
  logic [DW-1:0] tx_head;
  logic [CW-1:0] tx_cnt;
  logic [DW-1:0] inp_data_q, inp_data_d;

  assign req[0] = bus.inp_req;
  assign req[1] = bus.out_req;

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    io_state_e     state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;

    always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      unique case (state_q)
        ST_IDLE: begin
          if (req[ch]) begin
            state_d = ST_WAIT;
            lat_d   = LW'(ACK_LAT - 1);
          end
        end
        ST_WAIT: begin
          if (!req[ch]) begin
            state_d = ST_IDLE;
          end else if (lat_q != '0) begin
            lat_d = lat_q - LW'(1);
          end else if (ready[ch]) begin
            state_d = ST_ACK;
          end
        end
        ST_ACK:  state_d = ST_REL;
        ST_REL:  if (!req[ch]) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        state_q <= ST_IDLE;
        lat_q   <= '0;
      end else begin
        state_q <= state_d;
        lat_q   <= lat_d;
      end
    end

    assign ack[ch]  = (state_q == ST_ACK);
    assign take[ch] = (state_q == ST_WAIT) && (state_d == ST_ACK);
  end

`ifdef IO_PORT_LOOPBACK_EN
  // In loopback the TX channel owns the RX write port; the stream side is shut out.
  assign rx_push      = loopback ? ack[1] : (bus.rx_valid & ~rx_full);
  assign rx_din       = loopback ? bus.out_data : bus.rx_data;
  assign tx_push      = ack[1] & ~loopback;
  assign ready[1]     = loopback ? ~rx_full : ~tx_full;
  assign bus.rx_ready = ~rx_full & ~loopback;
`else
  assign rx_push      = bus.rx_valid & ~rx_full;
  assign rx_din       = bus.rx_data;
  assign tx_push      = ack[1];
  assign ready[1]     = ~tx_full;
  assign bus.rx_ready = ~rx_full;
`endif
  assign ready[0] = ~rx_empty;

  io_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (rx_push),
    .din   (rx_din),
    .pop   (ack[0]),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt),
    .head  (rx_head)
  );

  io_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (tx_push),
    .din   (bus.out_data),
    .pop   (bus.tx_ready),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt),
    .head  (tx_head)
  );

  // Word is captured as the RX channel commits to ACK and held until the next one.
  always_comb begin
    inp_data_d = inp_data_q;
    if (take[0]) inp_data_d = rx_head;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) inp_data_q <= '0;
    else        inp_data_q <= inp_data_d;
  end

  assign bus.inp_ack  = ack[0];
  assign bus.inp_data = inp_data_q;
  assign bus.out_ack  = ack[1];
  assign bus.tx_valid = ~tx_empty;
  assign bus.tx_data  = tx_head;
  assign bus.rx_count = rx_cnt;
  assign bus.tx_count = tx_cnt;

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: directed handshake cases plus a
// randomized mix checked against queue-based FIFO models (IO_PORT_LOOPBACK_EN aware).
module tb_io_port_responder;
  localparam int DW      = 16;
  localparam int DEPTH   = 8;
  localparam int ACK_LAT = 1;
  localparam int LAT_MAX = 30;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  io_port_responder_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
`ifdef IO_PORT_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  io_port_responder #(.DW(DW), .DEPTH(DEPTH), .ACK_LAT(ACK_LAT)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
`ifdef IO_PORT_LOOPBACK_EN
    ,
    .loopback (loopback)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] rx_m[$];
  logic [DW-1:0] tx_m[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic src_push(input logic [DW-1:0] w);
    check("rx_ready", bus.rx_ready, (rx_m.size() < DEPTH));
    bus.rx_valid = 1'b1;
    bus.rx_data  = w;
    step();
    bus.rx_valid = 1'b0;
    if (rx_m.size() < DEPTH) rx_m.push_back(w);
    check("rx_count_push", bus.rx_count, rx_m.size());
  endtask

  task automatic sink_pop();
    check("tx_valid", bus.tx_valid, (tx_m.size() > 0));
    if (tx_m.size() > 0) check("tx_data", bus.tx_data, tx_m[0]);
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    if (tx_m.size() > 0) void'(tx_m.pop_front());
    check("tx_count_pop", bus.tx_count, tx_m.size());
  endtask

  task automatic cpu_read(input string tag);
    logic [DW-1:0] exp;
    int lat;
    bit seen;
    exp = rx_m.pop_front();
    bus.inp_req = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < LAT_MAX) begin
      step();
      lat++;
      seen = bus.inp_ack;
    end
    check({tag, "_lat"}, lat, ACK_LAT + 1);
    check({tag, "_data"}, bus.inp_data, exp);
    bus.inp_req = 1'b0;
    step();
    check({tag, "_pulse"}, bus.inp_ack, 1'b0);
    check({tag, "_rxcnt"}, bus.rx_count, rx_m.size());
    step();
  endtask

  task automatic cpu_write(input string tag, input logic [DW-1:0] w, input bit to_rx);
    int lat;
    bit seen;
    bus.out_data = w;
    bus.out_req  = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < LAT_MAX) begin
      step();
      lat++;
      seen = bus.out_ack;
    end
    check({tag, "_lat"}, lat, ACK_LAT + 1);
    bus.out_req = 1'b0;
    step();
    check({tag, "_pulse"}, bus.out_ack, 1'b0);
    if (to_rx) rx_m.push_back(w);
    else       tx_m.push_back(w);
    check({tag, "_txcnt"}, bus.tx_count, tx_m.size());
    check({tag, "_rxcnt"}, bus.rx_count, rx_m.size());
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acks;
    int lat;
    logic [DW-1:0] w;

    bus.inp_req  = 1'b0;
    bus.out_req  = 1'b0;
    bus.out_data = '0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inp_ack", bus.inp_ack, 1'b0);
    check("rst_out_ack", bus.out_ack, 1'b0);
    check("rst_inp_data", bus.inp_data, '0);
    check("rst_rx_ready", bus.rx_ready, 1'b1);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_rx_count", bus.rx_count, 0);
    check("rst_tx_count", bus.tx_count, 0);
    rst_b = 1'b1;
    step();

    // Two source words read back in order.
    src_push(16'h1234);
    src_push(16'hABCD);
    check("rx_count_two", bus.rx_count, 2);
    cpu_read("rd_a");
    cpu_read("rd_b");
    check("rx_count_zero", bus.rx_count, 0);

    // Read request parked on an empty RX FIFO.
    bus.inp_req = 1'b1;
    acks = 0;
    repeat (10) begin
      step();
      if (bus.inp_ack) acks++;
    end
    check("empty_stall_acks", acks, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 16'h00FF;
    lat = 0;
    acks = 0;
    while (acks == 0 && lat < LAT_MAX) begin
      step();
      bus.rx_valid = 1'b0;
      lat++;
      if (bus.inp_ack) acks++;
    end
    check("empty_release_lat", lat, 2);
    check("empty_release_data", bus.inp_data, 16'h00FF);
    bus.inp_req = 1'b0;
    step();
    step();
    check("empty_release_rxcnt", bus.rx_count, 0);

    // Fill TX with the sink stalled; ninth write waits for a slot.
    for (int i = 0; i < DEPTH; i++) cpu_write("fill", DW'(16'h1000 + i), 1'b0);
    check("tx_full_count", bus.tx_count, DEPTH);
    bus.out_data = 16'h2009;
    bus.out_req  = 1'b1;
    acks = 0;
    repeat (10) begin
      step();
      if (bus.out_ack) acks++;
    end
    check("full_stall_acks", acks, 0);
    check("full_stall_txcnt", bus.tx_count, DEPTH);
    check("full_head", bus.tx_data, tx_m[0]);
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    void'(tx_m.pop_front());
    lat = 0;
    acks = 0;
    while (acks == 0 && lat < LAT_MAX) begin
      step();
      lat++;
      if (bus.out_ack) acks++;
    end
    check("full_release_lat", lat, 1);
    bus.out_req = 1'b0;
    step();
    tx_m.push_back(16'h2009);
    check("full_release_txcnt", bus.tx_count, DEPTH);
    step();
    while (tx_m.size() > 0) sink_pop();
    check("drained_tx_valid", bus.tx_valid, 1'b0);

    // Req held past the ack: one ack per request, re-arm after a one-cycle drop.
    bus.out_data = 16'h3001;
    bus.out_req  = 1'b1;
    acks = 0;
    repeat (7) begin
      step();
      if (bus.out_ack) acks++;
    end
    check("held_req_acks", acks, 1);
    bus.out_req = 1'b0;
    step();
    bus.out_data = 16'h3002;
    bus.out_req  = 1'b1;
    acks = 0;
    repeat (6) begin
      step();
      if (bus.out_ack) acks++;
    end
    check("rearm_acks", acks, 1);
    bus.out_req = 1'b0;
    step();
    step();
    tx_m.push_back(16'h3001);
    tx_m.push_back(16'h3002);
    check("held_txcnt", bus.tx_count, 2);
    check("held_head", bus.tx_data, 16'h3001);

    // Reset asserted while the TX channel is in WAIT.
    bus.out_data = 16'h4444;
    bus.out_req  = 1'b1;
    step();
    rst_b = 1'b0;
    #1;
    bus.out_req = 1'b0;
    acks = 0;
    repeat (3) begin
      step();
      if (bus.out_ack) acks++;
    end
    rst_b = 1'b1;
    repeat (3) begin
      step();
      if (bus.out_ack) acks++;
    end
    rx_m.delete();
    tx_m.delete();
    check("rst_wait_acks", acks, 0);
    check("rst_wait_txcnt", bus.tx_count, 0);
    check("rst_wait_tx_valid", bus.tx_valid, 1'b0);
    check("rst_wait_inp_data", bus.inp_data, '0);
    check("rst_wait_rx_ready", bus.rx_ready, 1'b1);
    check("rst_wait_inp_ack", bus.inp_ack, 1'b0);

`ifdef IO_PORT_LOOPBACK_EN
    loopback = 1'b1;
    #1;
    check("lb_rx_ready", bus.rx_ready, 1'b0);
    cpu_write("lb_wr", 16'h5A5A, 1'b1);
    check("lb_tx_valid", bus.tx_valid, 1'b0);
    cpu_read("lb_rd");
    check("lb_tx_valid_after", bus.tx_valid, 1'b0);
    loopback = 1'b0;
    step();
`endif

    // Randomized mix; pushes are weighted so RX reaches full and refusals are exercised.
    for (int n = 0; n < 150; n++) begin
      int op;
      op = $urandom_range(0, 5);
      w  = DW'($urandom);
      if (op <= 2) begin
        src_push(w);
      end else if (op == 3) begin
        if (rx_m.size() > 0) cpu_read("rnd_rd");
      end else if (op == 4) begin
        if (tx_m.size() < DEPTH) cpu_write("rnd_wr", w, 1'b0);
      end else begin
        sink_pop();
      end
    end
    while (rx_m.size() > 0) cpu_read("final_rd");
    while (tx_m.size() > 0) sink_pop();
    check("final_rx_count", bus.rx_count, 0);
    check("final_tx_count", bus.tx_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
